// File: rtl/kim_mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and data memory (slave).
interface kim_mem_wb_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  dmem_req;
  logic                  dmem_we;
  logic [DATA_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_ack;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/kim_mem_wb_stage.sv
// MEM stage and MEM/WB register of the pipelined MIPS core: one load/store per instruction on a
// variable-latency req/ack bus, upstream stall while outstanding, bounded wait with timeout abort.
module kim_mem_wb_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemtoReg_i,
    input  logic                      MemWrite_i,
    input  logic                      RegWrite_i,
    input  logic [DATA_WIDTH-1:0]     alu_result_i,
    input  logic [DATA_WIDTH-1:0]     w_data_to_mem_i,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_Rt_or_Rd_i,
    kim_mem_wb_stage_if.master        dmem,
    output logic                      mem_stall_o,
    output logic                      MemtoReg_reg_o,
    output logic                      RegWrite_reg_o,
    output logic [DATA_WIDTH-1:0]     mem_rdata_reg_o,
    output logic [DATA_WIDTH-1:0]     alu_result_reg_o,
    output logic [REG_ADDR_WIDTH-1:0] MEM_WB_Rt_or_Rd_reg_o,
    output logic                      mem_err_reg_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

    logic            access;
    logic            is_load;
    logic            timeout_hit;
    logic            stall;

    logic                      MemtoReg_q, MemtoReg_d;
    logic                      RegWrite_q, RegWrite_d;
    logic [DATA_WIDTH-1:0]     mem_rdata_q, mem_rdata_d;
    logic [DATA_WIDTH-1:0]     alu_result_q, alu_result_d;
    logic [REG_ADDR_WIDTH-1:0] dest_q, dest_d;
    logic                      mem_err_q, mem_err_d;

    // A store wins when both MemtoReg and MemWrite are set.
    assign access  = MemtoReg_i | MemWrite_i;
    assign is_load = MemtoReg_i & ~MemWrite_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (access && !dmem.dmem_ack) begin
                    state_d    = WAIT;
                    wait_cnt_d = CW'(1);
                end
            end
            WAIT: begin
                if (!access || dmem.dmem_ack || timeout_hit) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Output logic; reset gates the request so it drops in the same cycle rst rises.
    always_comb begin
        timeout_hit       = (state_q == WAIT) && !dmem.dmem_ack &&
                            (wait_cnt_q == CW'(TIMEOUT_CYCLES));
        dmem.dmem_req     = access & ~rst;
        dmem.dmem_we      = MemWrite_i;
        dmem.dmem_addr    = alu_result_i;
        dmem.dmem_wdata   = w_data_to_mem_i;
        stall             = dmem.dmem_req & ~dmem.dmem_ack & ~timeout_hit;
        mem_stall_o       = stall;
    end

    // MEM/WB next values: bubble while stalled, abort marker on timeout, else capture.
    always_comb begin
        MemtoReg_d   = 1'b0;
        RegWrite_d   = 1'b0;
        mem_err_d    = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        alu_result_d = alu_result_q;
        dest_d       = dest_q;
        if (!stall) begin
            alu_result_d = alu_result_i;
            dest_d       = EX_MEM_Rt_or_Rd_i;
            if (timeout_hit) begin
                mem_err_d   = 1'b1;
                mem_rdata_d = '0;
            end else begin
                RegWrite_d  = RegWrite_i;
                MemtoReg_d  = is_load;
                mem_rdata_d = (is_load && dmem.dmem_ack) ? dmem.dmem_rdata : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            MemtoReg_q   <= 1'b0;
            RegWrite_q   <= 1'b0;
            mem_rdata_q  <= '0;
            alu_result_q <= '0;
            dest_q       <= '0;
            mem_err_q    <= 1'b0;
        end else begin
            MemtoReg_q   <= MemtoReg_d;
            RegWrite_q   <= RegWrite_d;
            mem_rdata_q  <= mem_rdata_d;
            alu_result_q <= alu_result_d;
            dest_q       <= dest_d;
            mem_err_q    <= mem_err_d;
        end
    end

    assign MemtoReg_reg_o        = MemtoReg_q;
    assign RegWrite_reg_o        = RegWrite_q;
    assign mem_rdata_reg_o       = mem_rdata_q;
    assign alu_result_reg_o      = alu_result_q;
    assign MEM_WB_Rt_or_Rd_reg_o = dest_q;
    assign mem_err_reg_o         = mem_err_q;

endmodule

// File: tb/tb_kim_mem_wb_stage.sv
// Randomized self-checking bench for kim_mem_wb_stage against a per-instruction transaction model.
module tb_kim_mem_wb_stage;

    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic           MemtoReg, MemWrite, RegWrite;
    logic [DW-1:0]  alu_result, w_data_to_mem;
    logic [RAW-1:0] dest_in;
    logic           mem_stall;
    logic           MemtoReg_reg, RegWrite_reg, mem_err_reg;
    logic [DW-1:0]  mem_rdata_reg, alu_result_reg;
    logic [RAW-1:0] dest_reg;

    kim_mem_wb_stage_if #(.DATA_WIDTH(DW)) bus ();

    kim_mem_wb_stage #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (RAW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .MemtoReg_i            (MemtoReg),
        .MemWrite_i            (MemWrite),
        .RegWrite_i            (RegWrite),
        .alu_result_i          (alu_result),
        .w_data_to_mem_i       (w_data_to_mem),
        .EX_MEM_Rt_or_Rd_i     (dest_in),
        .dmem                  (bus.master),
        .mem_stall_o           (mem_stall),
        .MemtoReg_reg_o        (MemtoReg_reg),
        .RegWrite_reg_o        (RegWrite_reg),
        .mem_rdata_reg_o       (mem_rdata_reg),
        .alu_result_reg_o      (alu_result_reg),
        .MEM_WB_Rt_or_Rd_reg_o (dest_reg),
        .mem_err_reg_o         (mem_err_reg)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model of the MEM/WB data registers that hold across bubbles
    logic [DW-1:0]  exp_alu  = '0;
    logic [DW-1:0]  exp_rd   = '0;
    logic [RAW-1:0] exp_dest = '0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_memtoreg"}, DW'(MemtoReg_reg), '0);
        check_eq({tag, "_regwrite"}, DW'(RegWrite_reg), '0);
        check_eq({tag, "_rdata"},    mem_rdata_reg,     '0);
        check_eq({tag, "_alu"},      alu_result_reg,    '0);
        check_eq({tag, "_dest"},     DW'(dest_reg),     '0);
        check_eq({tag, "_err"},      DW'(mem_err_reg),  '0);
    endtask

    // lat = cycles without ack before ack arrives (0 = same cycle); lat > TO never acks.
    // rst_at >= 0 asserts reset once that many wait cycles have elapsed.
    task automatic run_instr(input logic mr, input logic mw, input logic rw,
                             input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                             input logic [RAW-1:0] dst, input int lat, input int rst_at,
                             output int stalls);
        bit            access  = mr | mw;
        bit            is_load = mr & ~mw;
        int            waited  = 0;
        bit            done    = 0;
        bit            ack, exp_stall, exp_abort;
        logic [DW-1:0] rd;
        stalls = 0;
        while (!done) begin
            @(negedge clk);
            MemtoReg = mr; MemWrite = mw; RegWrite = rw;
            alu_result = alu; w_data_to_mem = wd; dest_in = dst;
            ack = access && (waited == lat);
            rd  = $urandom;
            bus.dmem_ack   = ack;
            bus.dmem_rdata = rd;
            if (rst_at >= 0 && waited == rst_at) begin
                rst = 1'b1;
                bus.dmem_ack = 1'b0;
                #1;
                check_eq("rst_req_drop", DW'(bus.dmem_req), '0);
                check_all_zero("rst_mid");
                @(negedge clk);
                rst = 1'b0;
                exp_alu = '0; exp_rd = '0; exp_dest = '0;
                return;
            end
            #1;
            exp_stall = access && !ack && (waited < TO);
            exp_abort = access && !ack && (waited == TO);
            check_eq("req",   DW'(bus.dmem_req),  DW'(access));
            check_eq("we",    DW'(bus.dmem_we),   DW'(mw));
            check_eq("addr",  bus.dmem_addr,      alu);
            check_eq("wdata", bus.dmem_wdata,     wd);
            check_eq("stall", DW'(mem_stall),     DW'(exp_stall));
            @(posedge clk);
            #1;
            if (exp_stall) begin
                check_eq("bub_regwrite", DW'(RegWrite_reg), '0);
                check_eq("bub_memtoreg", DW'(MemtoReg_reg), '0);
                check_eq("bub_err",      DW'(mem_err_reg),  '0);
                check_eq("bub_alu_hold", alu_result_reg,    exp_alu);
                check_eq("bub_rd_hold",  mem_rdata_reg,     exp_rd);
                check_eq("bub_dst_hold", DW'(dest_reg),     DW'(exp_dest));
                waited++;
                stalls++;
                if (waited > TO + 1) begin
                    n_checks++; n_fail++;
                    $display("FAIL watchdog: waited %0d required <= %0d", waited, TO);
                    done = 1;
                end
            end else begin
                exp_alu  = alu;
                exp_dest = dst;
                exp_rd   = (!exp_abort && is_load) ? rd : '0;
                check_eq("wb_regwrite", DW'(RegWrite_reg), exp_abort ? '0 : DW'(rw));
                check_eq("wb_memtoreg", DW'(MemtoReg_reg), exp_abort ? '0 : DW'(is_load));
                check_eq("wb_rdata",    mem_rdata_reg,     exp_rd);
                check_eq("wb_alu",      alu_result_reg,    exp_alu);
                check_eq("wb_dest",     DW'(dest_reg),     DW'(exp_dest));
                check_eq("wb_err",      DW'(mem_err_reg),  DW'(exp_abort));
                done = 1;
            end
        end
        // Error flag must be a single-cycle pulse
        if (exp_abort) begin
            @(negedge clk);
            MemtoReg = 1'b0; MemWrite = 1'b0; RegWrite = 1'b0;
            bus.dmem_ack = 1'b0;
            @(posedge clk);
            #1;
            check_eq("err_pulse_end", DW'(mem_err_reg), '0);
            exp_alu = alu_result; exp_dest = dest_in; exp_rd = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int st;
        rst = 1'b1;
        MemtoReg = 0; MemWrite = 0; RegWrite = 0;
        alu_result = '0; w_data_to_mem = '0; dest_in = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        check_eq("reset_req", DW'(bus.dmem_req), '0);
        rst = 1'b0;

        // 1: ALU op
        run_instr(0, 0, 1, 32'h0000_002A, 32'h0, 5'd5, 0, -1, st);
        check_eq("t1_stalls", st, 0);
        // 2: zero-wait load
        run_instr(1, 0, 1, 32'h100, 32'h0, 5'd7, 0, -1, st);
        check_eq("t2_stalls", st, 0);
        // 3: store acked after 3 cycles
        run_instr(0, 1, 0, 32'h104, 32'h1234, 5'd0, 3, -1, st);
        check_eq("t3_stalls", st, 3);
        // 4: load never acked -> timeout abort
        run_instr(1, 0, 1, 32'h200, 32'h0, 5'd9, 1000, -1, st);
        check_eq("t4_stalls", st, TO);
        // 5: reset during WAIT cycle 2, then a normal load
        run_instr(1, 0, 1, 32'h300, 32'h0, 5'd11, 10, 2, st);
        run_instr(1, 0, 1, 32'h304, 32'h0, 5'd12, 2, -1, st);
        check_eq("t5_stalls", st, 2);
        // 6: ack on the exact timeout cycle completes
        run_instr(1, 0, 1, 32'h400, 32'h0, 5'd13, TO, -1, st);
        check_eq("t6_stalls", st, TO);
        // both MemtoReg and MemWrite: treated as store
        run_instr(1, 1, 0, 32'h500, 32'hCAFE, 5'd3, 1, -1, st);

        for (int i = 0; i < 150; i++) begin
            int unsigned kind = $urandom_range(0, 3);
            int unsigned r    = $urandom_range(0, 9);
            int lat;
            if (r < 5)       lat = 0;
            else if (r < 8)  lat = int'($urandom_range(1, 5));
            else if (r == 8) lat = TO;
            else             lat = TO + 1;
            run_instr(kind == 1 || kind == 3, kind >= 2, 1'($urandom),
                      $urandom, $urandom, RAW'($urandom), lat, -1, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
